// File: rtl/xbar_output_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_output_arbiter
//
// Packet arbiter for one crossbar output port. Keeps a rotating priority
// order of the input sources, grants the first requesting source in that
// order, holds the grant for the whole packet and then moves the winner to
// the lowest-priority slot (least-recently-granted first).
//
// Handshake: a beat transfers ("fires") in any cycle where the grant is held,
// the granted source presents src_valid and the output asserts dst_ready.
// src_ready is driven only from registered grant state and dst_ready, so it
// never depends on src_valid.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   src_valid        per-source beat valid; doubles as the request
//   src_last         per-source last-beat flag, qualified by src_valid
//   dst_ready        output port can accept a beat
//   grant_valid      a grant is currently held
//   grant_number     granted source index (data mux select)
//   grant_onehot     one-hot of grant_number, zero while no grant is held
//   src_ready        dst_ready & grant_valid, routed to the granted source
//   burst_abort      one-cycle pulse after a packet hit the beat limit
//   priority_array   current order, entry 0 = highest priority
//   dbg_state        FSM state (0 = IDLE, 1 = BUSY)
//   dbg_beat_cnt     beats fired in the current packet
// ---------------------------------------------------------------------------
module xbar_output_arbiter #(
  parameter int candidate = 4,
  parameter int MAX_BEATS = 16,
  localparam int IDW = $clog2(candidate),
  localparam int CW  = $clog2(MAX_BEATS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [candidate-1:0]              src_valid,
  input  logic [candidate-1:0]              src_last,
  input  logic                              dst_ready,
  output logic                              grant_valid,
  output logic [IDW-1:0]                    grant_number,
  output logic [candidate-1:0]              grant_onehot,
  output logic [candidate-1:0]              src_ready,
  output logic                              burst_abort,
  output logic [candidate-1:0][IDW-1:0]     priority_array,
  output logic [0:0]                        dbg_state,
  output logic [CW-1:0]                     dbg_beat_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]                    state_q, state_d;
  logic [IDW-1:0]                grant_number_q, grant_number_d;
  logic [CW-1:0]                 beat_cnt_q, beat_cnt_d;
  logic                          burst_abort_q, burst_abort_d;
  logic [candidate-1:0][IDW-1:0] prio_q, prio_d;

  logic                          winner_found;
  logic [IDW-1:0]                winner_id;
  logic [candidate-1:0][IDW-1:0] prio_rot;
  int                            grant_pos;
  logic                          fire;
  logic [CW-1:0]                 beat_inc;

  // First requesting source when scanning from highest priority down.
  always_comb begin
    winner_found = 1'b0;
    winner_id    = '0;
    for (int i = 0; i < candidate; i++) begin
      if (!winner_found && src_valid[prio_q[i]]) begin
        winner_found = 1'b1;
        winner_id    = prio_q[i];
      end
    end
  end

  // Order after releasing the current grant: pull the granted ID out of its
  // slot, close the gap, and append it at the tail.
  always_comb begin
    grant_pos = 0;
    for (int i = 0; i < candidate; i++) begin
      if (prio_q[i] == grant_number_q) grant_pos = i;
    end
    for (int i = 0; i < candidate; i++) begin
      if (i == candidate - 1)  prio_rot[i] = grant_number_q;
      else if (i < grant_pos)  prio_rot[i] = prio_q[i];
      else                     prio_rot[i] = prio_q[(i + 1) % candidate];
    end
  end

  assign fire     = (state_q == ST_BUSY) & src_valid[grant_number_q] & dst_ready;
  assign beat_inc = beat_cnt_q + CW'(1);

  always_comb begin
    state_d        = state_q;
    grant_number_d = grant_number_q;
    beat_cnt_d     = beat_cnt_q;
    burst_abort_d  = 1'b0;
    prio_d         = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (winner_found) begin
          state_d        = ST_BUSY;
          grant_number_d = winner_id;
          beat_cnt_d     = '0;
        end
      end
      ST_BUSY: begin
        // Idle cycles (no valid or no ready) never advance the count.
        if (fire) begin
          beat_cnt_d = beat_inc;
          if (src_last[grant_number_q]) begin
            // A last beat that also reaches the limit is a normal completion.
            state_d    = ST_IDLE;
            prio_d     = prio_rot;
            beat_cnt_d = '0;
          end else if (beat_inc == CW'(MAX_BEATS)) begin
            state_d       = ST_IDLE;
            prio_d        = prio_rot;
            beat_cnt_d    = '0;
            burst_abort_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_number_q <= '0;
      beat_cnt_q     <= '0;
      burst_abort_q  <= 1'b0;
      for (int i = 0; i < candidate; i++) prio_q[i] <= IDW'(i);
    end else begin
      state_q        <= state_d;
      grant_number_q <= grant_number_d;
      beat_cnt_q     <= beat_cnt_d;
      burst_abort_q  <= burst_abort_d;
      prio_q         <= prio_d;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (state_q == ST_BUSY) grant_onehot[grant_number_q] = 1'b1;
  end

  assign grant_valid    = (state_q == ST_BUSY);
  assign grant_number   = grant_number_q;
  assign src_ready      = dst_ready ? grant_onehot : '0;
  assign burst_abort    = burst_abort_q;
  assign priority_array = prio_q;
  assign dbg_state      = state_q;
  assign dbg_beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_xbar_output_arbiter.sv
module tb_xbar_output_arbiter;

  localparam int N   = 4;
  localparam int MB  = 16;
  localparam int IDW = 2;
  localparam int CW  = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          src_valid = '0;
  logic [N-1:0]          src_last = '0;
  logic                  dst_ready = 1'b0;
  logic                  grant_valid;
  logic [IDW-1:0]        grant_number;
  logic [N-1:0]          grant_onehot;
  logic [N-1:0]          src_ready;
  logic                  burst_abort;
  logic [N-1:0][IDW-1:0] priority_array;
  logic [0:0]            dbg_state;
  logic [CW-1:0]         dbg_beat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  xbar_output_arbiter #(.candidate(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_last(src_last),
    .dst_ready(dst_ready), .grant_valid(grant_valid), .grant_number(grant_number),
    .grant_onehot(grant_onehot), .src_ready(src_ready), .burst_abort(burst_abort),
    .priority_array(priority_array), .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Priority kept as a list of IDs; rotation is delete + push_back.
  int order[$];
  bit m_busy;
  int m_gnum;
  int m_beats;
  bit m_abort;

  task automatic model_release();
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == m_gnum) begin
        order.delete(i);
        break;
      end
    end
    order.push_back(m_gnum);
    m_busy  = 1'b0;
    m_beats = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order   = {0, 1, 2, 3};
      m_busy  = 1'b0;
      m_gnum  = 0;
      m_beats = 0;
      m_abort = 1'b0;
    end else begin
      m_abort = 1'b0;
      if (!m_busy) begin
        for (int i = 0; i < order.size(); i++) begin
          if (!m_busy && src_valid[order[i]]) begin
            m_busy  = 1'b1;
            m_gnum  = order[i];
            m_beats = 0;
          end
        end
      end else if (src_valid[m_gnum] && dst_ready) begin
        m_beats++;
        if (src_last[m_gnum]) begin
          model_release();
        end else if (m_beats == MB) begin
          model_release();
          m_abort = 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] model_prio();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i*IDW +: IDW] = IDW'(order[i]);
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare process: every cycle, mid-way between edges.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("grant_valid", 32'(grant_valid), 32'(m_busy));
      chk("dbg_state", 32'(dbg_state), 32'(m_busy));
      if (m_busy) begin
        chk("grant_number", 32'(grant_number), 32'(m_gnum));
        chk("beat_cnt", 32'(dbg_beat_cnt), 32'(m_beats));
      end
      chk("grant_onehot", 32'(grant_onehot), m_busy ? (32'd1 << m_gnum) : 32'd0);
      chk("src_ready", 32'(src_ready), (m_busy && dst_ready) ? (32'd1 << m_gnum) : 32'd0);
      chk("burst_abort", 32'(burst_abort), 32'(m_abort));
      chk("priority_array", 32'(priority_array), model_prio());
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; returns 3 time units later with
  // outputs settled and the next rising edge still ahead.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    @(negedge clk);
    src_valid = v;
    src_last  = l;
    dst_ready = r;
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    src_valid = '0;
    src_last  = '0;
    dst_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    dst_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst grant_valid", 32'(grant_valid), 32'd0);
    chk("rst grant_number", 32'(grant_number), 32'd0);
    chk("rst grant_onehot", 32'(grant_onehot), 32'd0);
    chk("rst src_ready", 32'(src_ready), 32'd0);
    chk("rst burst_abort", 32'(burst_abort), 32'd0);
    chk("rst priority", 32'(priority_array), 32'h0e4);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 1: everyone requests, single-beat packets
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      chk("t1 grant_valid", 32'(grant_valid), 32'(i % 2));
      if (i % 2 == 1) chk("t1 grant_number", 32'(grant_number), 32'(exp_seq[i/2]));
      if (i == 2) chk("t1 priority", 32'(priority_array), 32'h39);
    end
    drive(4'b0000, 4'b0000, 1'b1);

    // 2: packet lock against a competing request
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0110, (i == 4) ? 4'b0100 : 4'b0000, 1'b1);
      chk("t2 locked grant", 32'(grant_number), 32'd2);
    end
    drive(4'b0010, 4'b0000, 1'b1);
    chk("t2 bubble", 32'(grant_valid), 32'd0);
    chk("t2 priority", 32'(priority_array), 32'hb4);
    drive(4'b0010, 4'b0010, 1'b1);
    chk("t2 next grant", 32'(grant_number), 32'd1);
    chk("t2 next valid", 32'(grant_valid), 32'd1);

    // 3: backpressure and valid gaps on source 0, source 2 waiting
    drive(4'b0001, 4'b0000, 1'b1);
    drive(4'b0101, 4'b0000, 1'b1);
    drive(4'b0101, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0101, 4'b0000, 1'b0);
      chk("t3 stall grant", 32'(grant_number), 32'd0);
      chk("t3 stall beats", 32'(dbg_beat_cnt), 32'd2);
      chk("t3 stall ready", 32'(src_ready), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 4'b0000, 1'b1);
      chk("t3 gap held", 32'(grant_valid), 32'd1);
      chk("t3 gap beats", 32'(dbg_beat_cnt), 32'd2);
      chk("t3 gap ready", 32'(src_ready), 32'h1);
    end
    drive(4'b0101, 4'b0000, 1'b1);
    drive(4'b0101, 4'b0001, 1'b1);
    chk("t3 beats before last", 32'(dbg_beat_cnt), 32'd3);
    drive(4'b0000, 4'b0000, 1'b1);
    chk("t3 no abort", 32'(burst_abort), 32'd0);
    chk("t3 priority", 32'(priority_array), 32'h1b);

    // 4: forced release, then last coinciding with the limit
    for (int i = 0; i < 17; i++) drive(4'b1000, 4'b0000, 1'b1);
    chk("t4 16th fire held", 32'(grant_valid), 32'd1);
    chk("t4 16th fire beats", 32'(dbg_beat_cnt), 32'd15);
    drive(4'b1000, 4'b0000, 1'b1);
    chk("t4 abort pulse", 32'(burst_abort), 32'd1);
    chk("t4 released", 32'(grant_valid), 32'd0);
    chk("t4 priority", 32'(priority_array), 32'hc6);
    for (int i = 0; i < 16; i++) begin
      drive(4'b1000, (i == 15) ? 4'b1000 : 4'b0000, 1'b1);
      if (i == 0) chk("t4 abort one cycle", 32'(burst_abort), 32'd0);
    end
    drive(4'b0000, 4'b0000, 1'b1);
    chk("t4 last at limit no abort", 32'(burst_abort), 32'd0);
    chk("t4 last at limit released", 32'(grant_valid), 32'd0);

    // 5: asynchronous reset in the middle of a packet
    drive(4'b0100, 4'b0000, 1'b1);
    drive(4'b0100, 4'b0000, 1'b1);
    chk("t5 busy before reset", 32'(grant_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5 async grant_valid", 32'(grant_valid), 32'd0);
    chk("t5 async src_ready", 32'(src_ready), 32'd0);
    chk("t5 async onehot", 32'(grant_onehot), 32'd0);
    chk("t5 async priority", 32'(priority_array), 32'h0e4);
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6: single requester
    for (int i = 0; i < 6; i++) begin
      drive(4'b0010, 4'b0010, 1'b1);
      chk("t6 grant_valid", 32'(grant_valid), 32'(i % 2));
      if (i % 2 == 1) chk("t6 grant_number", 32'(grant_number), 32'd1);
    end
    drive(4'b0000, 4'b0000, 1'b1);
    chk("t6 priority", 32'(priority_array), 32'h78);

    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xbar_output_arbiter.md
# xbar_output_arbiter

- Per-output-port packet arbiter for the crossbar.
- Holds the rotating priority order for `candidate` input sources and picks a winner each arbitration cycle, scanning sources in priority order.
- Locks the grant for a whole packet, then moves the winner to lowest priority (least-recently-granted).
- Its grant number drives the output port's data mux select.

## Interface

- `candidate`, default 4: number of input sources, ≥2. `IDW = $clog2(candidate)`.
- `MAX_BEATS`, default 16: maximum beats per packet before a forced release. `CW = $clog2(MAX_BEATS+1)`.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  candidate  per-source beat valid; also acts as the request.
- `src_last`  in  candidate  per-source last-beat flag, qualified by `src_valid`.
- `dst_ready`  in  1  output port accepts a beat.
- `grant_valid`  out  1  a grant is held.
- `grant_number`  out  IDW  granted source index (mux select).
- `grant_onehot`  out  candidate  one-hot of `grant_number`, all zero when `grant_valid=0`.
- `src_ready`  out  candidate  `dst_ready & grant_valid` routed to the granted source only.
- `burst_abort`  out  1  one-cycle pulse on a forced release.
- `priority_array`  out  IDW × candidate  current order; entry 0 is highest priority. Exposed for debug.

## Operation

**Fire condition:** a beat fires when `fire = grant_valid & src_valid[grant_number] & dst_ready`.

**IDLE state**
- If `src_valid` is nonzero: pick the first `priority_array[i]` (i ascending) whose `src_valid` bit is set.
- Register it into `grant_number`, set `grant_valid`, clear `beat_cnt`, go to BUSY.
- If `src_valid` is zero: stay in IDLE.

**BUSY state**
- On each fire, `beat_cnt` increments.
- A fire with `src_last[grant_number]=1` completes the packet: go to IDLE and rotate priority.
- A fire without last where `beat_cnt+1 == MAX_BEATS` is a forced release: go to IDLE, rotate priority, pulse `burst_abort`.
- If the granted source drops `src_valid` mid-packet, the grant is held and the block waits. No timeout applies to idle cycles; only fired beats count.
- Requests from other sources never preempt the grant.

**Priority rotation**
- The granted ID is removed from its position k.
- Entries k+1..candidate-1 shift up by one.
- The granted ID is written to position candidate-1.
- The result is always a permutation of 0..candidate-1.

**Reset** (asynchronous, effective immediately):
- State = IDLE.
- `priority_array[i] = i`.
- `grant_valid = 0`, `grant_number = 0`, `grant_onehot = 0`, `src_ready = 0`, `burst_abort = 0`, `beat_cnt = 0`.
- Reset in the middle of a packet drops the grant; the partial packet is the sender's problem.

## Timing

- **Arbitration latency:** request seen in IDLE at edge N → `grant_valid=1` and `grant_number` valid after edge N+1. The first beat can fire in cycle N+1.
- **Release:** last beat fires in cycle M → after edge M+1, `grant_valid=0` and `priority_array` is rotated. `burst_abort` is high for cycle M+1 only, on a forced release.
- The next grant is earliest after edge M+2: one mandatory bubble cycle per packet.
- Single-beat packets: grant in cycle N+1, back to IDLE at N+2, so the maximum rate is one packet per 2 cycles per port.
- `src_ready` and `grant_onehot` are combinational from registered state plus `dst_ready`. There is no path from `src_valid` to `src_ready`.
- `src_last` is ignored when that source's `src_valid=0` or it is not granted.
- Simultaneous last and beat-limit in the same fire: treat as a normal last (`burst_abort=0`).

## Test plan

With candidate=4, MAX_BEATS=16:

1. **Reset, all request.** Reset, then `src_valid=4'b1111`, single-beat packets, `dst_ready=1`. Grants go 0,1,2,3,0 with `grant_valid` high every other cycle. `priority_array` after the first packet is [1,2,3,0].
2. **Packet lock.** Source 2 sends a 5-beat packet while source 1 requests from the second cycle. `grant_number` stays 2 for all 5 fires. Source 1 is granted 2 cycles after source 2's last fire. Priority then reads [0,1,3,2].
3. **Backpressure and valid gaps.** Hold `dst_ready=0` for 3 cycles and drop `src_valid[grant]` for 2 cycles mid-packet. The grant is held, `beat_cnt` counts only fired beats, and no `burst_abort` occurs.
4. **Forced release.** Source 3 streams beats with no last. After the 16th fire, `burst_abort` pulses for 1 cycle, `grant_valid` drops, and priority moves 3 to the tail.
5. **Async reset mid-packet.** Assert `rst_n=0` in BUSY between edges. `grant_valid` and `src_ready` go 0 immediately, and `priority_array` returns to [0,1,2,3].
6. **Single requester.** Only source 1 requests, with repeated 1-beat packets. Source 1 is granted every second cycle. Priority after 3 packets is [0,2,3,1], unchanged after the first rotation.
